// File: rtl/cache_line_adapter_if.sv
// cache_line_adapter_if
//   Bundles the line-wide cache port and the word-wide memory port of
//   cache_line_adapter.
//   Line side : line_addr, line_read, line_write, line_wdata (cache -> adapter)
//               line_rdata, line_resp (adapter -> cache)
//   Word side : word_addr, word_read, word_write, word_wdata (adapter -> memory)
//               word_rdata, word_resp (memory -> adapter)
//   master : the environment (cache plus memory) that drives requests and
//            memory responses.
//   slave  : the adapter itself.
interface cache_line_adapter_if #(
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WORDS = 8
);
  localparam int LINE_WIDTH = WORD_WIDTH * LINE_WORDS;

  logic [15:0]           line_addr;
  logic                  line_read;
  logic                  line_write;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;
  logic [15:0]           word_addr;
  logic                  word_read;
  logic                  word_write;
  logic [WORD_WIDTH-1:0] word_wdata;
  logic [WORD_WIDTH-1:0] word_rdata;
  logic                  word_resp;

  modport master (
    output line_addr, line_read, line_write, line_wdata, word_rdata, word_resp,
    input  line_rdata, line_resp, word_addr, word_read, word_write, word_wdata
  );

  modport slave (
    input  line_addr, line_read, line_write, line_wdata, word_rdata, word_resp,
    output line_rdata, line_resp, word_addr, word_read, word_write, word_wdata
  );
endinterface

// File: rtl/cache_line_adapter.sv
// cache_line_adapter
//   Converts one line read/write request from cache_control into LINE_WORDS
//   word transfers on a word-wide memory, then returns a one-cycle line_resp.
//   Reads are assembled into a registered line buffer (line_rdata), writes
//   serialise a copy of line_wdata latched at request time.
// Ports
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high; aborts any transfer without line_resp
//   bus   : cache_line_adapter_if.slave (line side and word side signals)
module cache_line_adapter #(
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WORDS = 8
) (
  input logic                 clk,
  input logic                 reset,
  cache_line_adapter_if.slave bus
);
  localparam int LINE_WIDTH     = WORD_WIDTH * LINE_WORDS;
  localparam int CNT_W          = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int LINE_BYTES     = BYTES_PER_WORD * LINE_WORDS;
  localparam logic [15:0] ALIGN_MASK = ~16'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ_BEAT, WRITE_BEAT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [15:0]           base_reg, base_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic [LINE_WIDTH-1:0] rdata_reg, rdata_next;
  logic [15:0]           beat_addr;

  // Base is line aligned, so adding the beat offset can never carry past
  // the line: the address stays inside [base, base+LINE_BYTES).
  assign beat_addr      = base_reg + 16'(cnt_reg) * 16'(BYTES_PER_WORD);
  assign bus.line_rdata = rdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      base_reg  <= base_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    base_next      = base_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    bus.line_resp  = 1'b0;
    bus.word_read  = 1'b0;
    bus.word_write = 1'b0;
    bus.word_addr  = '0;
    bus.word_wdata = '0;

    case (state_reg)
      IDLE: begin
        // Write-back first so a dirty victim reaches memory before the fill.
        if (bus.line_write) begin
          base_next  = bus.line_addr & ALIGN_MASK;
          wdata_next = bus.line_wdata;
          cnt_next   = '0;
          state_next = WRITE_BEAT;
        end else if (bus.line_read) begin
          base_next  = bus.line_addr & ALIGN_MASK;
          cnt_next   = '0;
          state_next = READ_BEAT;
        end
      end
      READ_BEAT: begin
        bus.word_read = 1'b1;
        bus.word_addr = beat_addr;
        if (bus.word_resp) begin
          rdata_next[cnt_reg*WORD_WIDTH +: WORD_WIDTH] = bus.word_rdata;
          if (cnt_reg == LAST_BEAT) state_next = DONE;
          else                      cnt_next   = cnt_reg + 1'b1;
        end
      end
      WRITE_BEAT: begin
        bus.word_write = 1'b1;
        bus.word_addr  = beat_addr;
        bus.word_wdata = wdata_reg[cnt_reg*WORD_WIDTH +: WORD_WIDTH];
        if (bus.word_resp) begin
          if (cnt_reg == LAST_BEAT) state_next = DONE;
          else                      cnt_next   = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        bus.line_resp = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
